// File: rtl/alu_addsub_seq.sv
// Sequential add/subtract ALU: one CHUNK-bit slice per cycle, LSB first,
// with a ripple carry kept in a register between cycles. Valid/ready
// handshake on both sides; the result is held in DONE until it is consumed.
module alu_addsub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             rdy;      // low in reset and until the first edge after it
  logic [WIDTH-1:0] a_q, b_q; // b_q already inverted for subtract
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_sl;
  logic [WIDTH-1:0] sum_nxt;
  logic             last;
  logic             accept;
  int               sh;

  assign accept    = in_valid & in_ready;
  assign last      = (cnt == CW'(N - 1));
  assign in_ready  = (state == IDLE) & rdy;
  assign out_valid = (state == DONE);

  // Current slice add and the partial result with that slice merged in
  always_comb begin
    sh      = int'(cnt) * CHUNK;
    a_sl    = CHUNK'(a_q >> sh);
    b_sl    = CHUNK'(b_q >> sh);
    {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
    sum_nxt = (out_sum & ~(WIDTH'({CHUNK{1'b1}}) << sh)) | (WIDTH'(s_sl) << sh);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = CALC;
      CALC:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-slice accumulation and final flag computation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      out_sum <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
    end else begin
      rdy <= 1'b1;
      if (accept) begin
        a_q   <= in_a;
        b_q   <= mode ? ~in_b : in_b;
        carry <= mode ? ~cin : cin;
        cnt   <= '0;
      end else if (state == CALC) begin
        carry   <= c_sl;
        out_sum <= sum_nxt;
        cnt     <= cnt + CW'(1);
        if (last) begin
          cout <= c_sl;
          // carry into the MSB recovered from the MSB sum bit, xor carry out
          ovf  <= (a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1]) ^ c_sl;
          zero <= (sum_nxt == '0);
          neg  <= sum_nxt[WIDTH-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_addsub_seq.sv
// Bench for alu_addsub_seq: arithmetic reference model plus per-cycle compare
// on the default 8-bit instance, directed literal cases, reset abort, and
// 16-bit instances at CHUNK=16 and CHUNK=1.
module tb_alu_addsub_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // default instance
  logic       in_valid = 0, in_ready, cin = 0, mode = 0, out_valid, out_ready = 0;
  logic [7:0] in_a = 0, in_b = 0, out_sum;
  logic       cout, ovf, zero, neg;

  alu_addsub_seq #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cin(cin), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .cout(cout), .ovf(ovf), .zero(zero), .neg(neg));

  // 16-bit instances share inputs
  logic        v16 = 0, c16 = 0, m16 = 0, or16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        rdy_w, vld_w, co_w, ov_w, z_w, n_w;
  logic        rdy_n, vld_n, co_n, ov_n, z_n, n_n;
  logic [15:0] s_w, s_n;

  alu_addsub_seq #(.WIDTH(16), .CHUNK(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy_w),
    .in_a(a16), .in_b(b16), .cin(c16), .mode(m16),
    .out_valid(vld_w), .out_ready(or16), .out_sum(s_w),
    .cout(co_w), .ovf(ov_w), .zero(z_w), .neg(n_w));

  alu_addsub_seq #(.WIDTH(16), .CHUNK(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy_n),
    .in_a(a16), .in_b(b16), .cin(c16), .mode(m16),
    .out_valid(vld_n), .out_ready(or16), .out_sum(s_n),
    .cout(co_n), .ovf(ov_n), .zero(z_n), .neg(n_n));

  typedef struct packed {
    logic [15:0] sum;
    logic        cout, ovf, zero, neg;
  } res_t;

  // Reference arithmetic: unsigned sum for result/carry, signed range for ovf
  function automatic res_t model_op(int w, longint a, longint b, longint c, logic m);
    res_t   r;
    longint mask, full, sa, sb, s, lim;
    mask = (longint'(1) << w) - 1;
    lim  = longint'(1) << (w - 1);
    full = m ? a + (mask - b) + (1 - c) : a + b + c;
    sa   = (a >= lim) ? a - (mask + 1) : a;
    sb   = (b >= lim) ? b - (mask + 1) : b;
    s    = m ? sa - sb - c : sa + sb + c;
    r.sum  = 16'(full & mask);
    r.cout = ((full >> w) & 1) != 0;
    r.ovf  = (s > lim - 1) || (s < -lim);
    r.zero = (full & mask) == 0;
    r.neg  = ((full >> (w - 1)) & 1) != 0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model of the default instance
  int   m_phase = 0;   // 0 waiting, 1 computing, 2 holding result
  int   m_left  = 0;
  logic m_rdy   = 0;
  res_t m_exp   = '0;
  int   m_done  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_rdy   <= 0;
    end else begin
      m_rdy <= 1;
      case (m_phase)
        0: if (m_rdy && in_valid) begin
             m_exp   <= model_op(8, in_a, in_b, cin, mode);
             m_left  <= 2;
             m_phase <= 1;
           end
        1: begin
             m_left <= m_left - 1;
             if (m_left == 1) m_phase <= 2;
           end
        default: if (out_ready) begin
             m_phase <= 0;
             m_done  <= m_done + 1;
           end
      endcase
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("handshake", {in_ready, out_valid}, {(m_phase == 0) && m_rdy, m_phase == 2});
    if (m_phase == 2)
      chk("result", {out_sum, cout, ovf, zero, neg},
          {m_exp.sum[7:0], m_exp.cout, m_exp.ovf, m_exp.zero, m_exp.neg});
  end

  // Directed operation with literal expectation {sum,cout,ovf,zero,neg}
  task automatic do_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic m, input int hold,
                       input logic [11:0] exp);
    int cyc;
    cyc = 0;
    out_ready = 0;
    while (!in_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk({nm, "_ready"}, in_ready, 1);
    in_a = a; in_b = b; cin = c; mode = m; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    in_a = 8'($urandom); in_b = 8'($urandom); cin = 1'($urandom); mode = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk({nm, "_lat"}, cyc, 2);
    chk({nm, "_out"}, {out_sum, cout, ovf, zero, neg}, exp);
    for (int i = 0; i < hold; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk({nm, "_hold"}, {in_ready, out_valid, out_sum, cout, ovf, zero, neg}, {2'b01, exp});
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({nm, "_release"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    int lw, ln, seen;
    res_t r;
    #1;
    chk("rst_outs", {in_ready, out_valid, out_sum, cout, ovf, zero, neg}, 0);
    #22 rst_n = 1;
    chk("rdy_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("rdy_after_edge", in_ready, 1);

    // pin the reference model itself
    r = model_op(8, 'h7F, 'h01, 0, 0);
    chk("model_add", {r.sum, r.cout, r.ovf, r.zero, r.neg}, {16'h0080, 4'b0101});
    r = model_op(8, 'h10, 'h01, 1, 1);
    chk("model_sub", {r.sum, r.cout}, {16'h000E, 1'b1});
    r = model_op(16, 'h8000, 'h0001, 0, 1);
    chk("model_sub16", {r.sum, r.cout, r.ovf}, {16'h7FFF, 2'b11});

    // 16-bit, full-width chunk vs single-bit chunk
    a16 = 16'h8000; b16 = 16'h0001; c16 = 0; m16 = 1; v16 = 1;
    @(posedge clk); #1;
    v16 = 0; a16 = 16'h1234; b16 = 16'hFFFF;
    lw = -1; ln = -1;
    for (int i = 0; i < 40 && (lw < 0 || ln < 0); i++) begin
      if (lw < 0 && vld_w) begin
        lw = i;
        chk("w16_out", {s_w, co_w, ov_w, z_w, n_w}, {16'h7FFF, 4'b1100});
      end
      if (ln < 0 && vld_n) begin
        ln = i;
        chk("n16_out", {s_n, co_n, ov_n, z_n, n_n}, {16'h7FFF, 4'b1100});
      end
      @(posedge clk); #1;
    end
    chk("w16_lat", lw, 1);
    chk("n16_lat", ln, 16);
    or16 = 1;
    @(posedge clk); #1;
    or16 = 0;

    // directed default-width cases
    do_op("add_ovf",   8'h7F, 8'h01, 0, 0, 0, {8'h80, 4'b0101});
    do_op("sub_eq",    8'h05, 8'h05, 0, 1, 0, {8'h00, 4'b1010});
    do_op("sub_neg",   8'h00, 8'h01, 0, 1, 0, {8'hFF, 4'b0001});
    do_op("add_carry", 8'hFF, 8'h00, 1, 0, 0, {8'h00, 4'b1010});
    do_op("sub_borrow",8'h10, 8'h01, 1, 1, 5, {8'h0E, 4'b1000});

    // reset in the middle of a computation
    in_a = 8'h55; in_b = 8'h22; cin = 0; mode = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("abort_outs", {in_ready, out_valid, out_sum, cout, ovf, zero, neg}, 0);
    @(posedge clk); #3 rst_n = 1;
    seen = 0;
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 0;
    chk("abort_no_valid", seen, 0);
    do_op("post_reset", 8'h12, 8'h34, 0, 0, 0, {8'h46, 4'b0000});

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom % 3) != 0;
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      cin       = 1'($urandom);
      mode      = 1'($urandom);
      out_ready = ($urandom % 2) != 0;
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("random_ops_done", m_done > 50, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
